// File: rtl/reg_ctrl_bank_if.sv
// Request/response bundle for the register-control bank.
// The master drives the request (addr/sel/wr/wdata/wstrb); the slave
// answers with ready, the one-cycle rvalid/rdata response and the err pulse.
interface reg_ctrl_bank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] addr;
    logic                  sel;
    logic                  wr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  ready;
    logic                  err;

    modport master (
        output addr,
        output sel,
        output wr,
        output wdata,
        output wstrb,
        input  rdata,
        input  rvalid,
        input  ready,
        input  err
    );

    modport slave (
        input  addr,
        input  sel,
        input  wr,
        input  wdata,
        input  wstrb,
        output rdata,
        output rvalid,
        output ready,
        output err
    );
endinterface

// File: rtl/reg_ctrl_bank.sv
// DEPTH-entry register bank behind a sel/wr/ready handshake.
// Writes complete at the accept edge with per-byte strobes; reads insert
// READ_WAIT wait states and answer with a single-cycle rvalid pulse.
// Any access to an address >= DEPTH touches nothing and raises a one-cycle err.
module reg_ctrl_bank #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 200,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = 32'h1234_5678,
    parameter int                    READ_WAIT  = 2
) (
    input  logic           clk,
    input  logic           rst,
    reg_ctrl_bank_if.slave bus
);

    // Byte-lane count follows directly from the data width.
    localparam int                  STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int                  IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_W     = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          READ_WAIT_C = 4'(READ_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when the address maps onto an implemented register.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    // Array index for an address; only meaningful when addr_in_range(a).
    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_req_ok;
    logic                  w_wr_hit;
    logic [IDX_W-1:0]      w_wr_idx;
    logic                  w_resp_ok;
    logic [DATA_WIDTH-1:0] w_resp_data;

    // ready is only ever high in IDLE, so accept implies the FSM is idle.
    assign w_accept    = bus.sel & r_ready;
    assign w_req_ok    = addr_in_range(bus.addr);
    assign w_wr_hit    = w_accept & bus.wr & w_req_ok;
    assign w_wr_idx    = addr_index(bus.addr);
    assign w_resp_ok   = addr_in_range(r_addr);
    assign w_resp_data = r_mem[addr_index(r_addr)];

    assign bus.ready  = r_ready;
    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
    assign bus.err    = r_err;

    // Register bank: reload RESET_VAL on reset, byte-masked update on an accepted in-range write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k[IDX_W-1:0]] <= RESET_VAL;
            end
        end else if (w_wr_hit) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (bus.wstrb[b]) begin
                    r_mem[w_wr_idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
                end
            end
        end
    end

    // Handshake FSM: accepts requests in IDLE, counts read wait states, drives the registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= {ADDR_WIDTH{1'b0}};
            r_ready  <= 1'b1;
            r_rdata  <= {DATA_WIDTH{1'b0}};
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // Response outputs are pulses: cleared unless set below.
            r_rdata  <= {DATA_WIDTH{1'b0}};
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (bus.wr) begin
                            // Write finishes at this edge; only an out-of-range target is reported.
                            r_err <= ~w_req_ok;
                        end else begin
                            // Read: freeze the address and hold off further requests.
                            r_addr  <= bus.addr;
                            r_ready <= 1'b0;
                            r_cnt   <= READ_WAIT_C;
                            if (READ_WAIT_C == 4'd0) begin
                                r_state <= ST_RESP;
                            end else begin
                                r_state <= ST_WAIT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    // Leave on the 1->0 step; a zero count is treated the same for robustness.
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Bank cannot change during a read, so this is the value at accept time.
                    r_rdata  <= w_resp_ok ? w_resp_data : {DATA_WIDTH{1'b0}};
                    r_rvalid <= 1'b1;
                    r_err    <= ~w_resp_ok;
                    r_ready  <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_ctrl_bank.sv
// Self-checking bench for reg_ctrl_bank: directed scenarios followed by a
// randomized mix of reads and writes, all checked against an array model.
module tb_reg_ctrl_bank;

    localparam int          AW    = 8;
    localparam int          DW    = 32;
    localparam int          DEPTH = 200;
    localparam int          RW    = 2;
    localparam logic [31:0] RV    = 32'h1234_5678;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_ctrl_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    reg_ctrl_bank #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .RESET_VAL(RV),
        .READ_WAIT(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model: one word per possible address; entries >= DEPTH are never used.
    logic [31:0] mem_m [0:255];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
        end
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem_m[i] = RV;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        return (int'(a) < DEPTH) ? mem_m[a] : 32'h0;
    endfunction

    // Single write accepted at the next edge; sampled 1 time unit after it.
    task automatic do_write(input string tag, input logic [7:0] a, input logic [31:0] wd,
                            input logic [3:0] strb);
        bus.sel   = 1'b1;
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = wd;
        bus.wstrb = strb;
        @(posedge clk); #1;
        check({tag, ".ready"},  32'(bus.ready),  32'd1);
        check({tag, ".err"},    32'(bus.err),    (int'(a) >= DEPTH) ? 32'd1 : 32'd0);
        check({tag, ".rvalid"}, 32'(bus.rvalid), 32'd0);
        if (int'(a) < DEPTH) mem_m[a] = merge(mem_m[a], wd, strb);
        bus.sel = 1'b0;
        bus.wr  = 1'b0;
    endtask

    // Single read: ready low for RW+1 cycles, then one rvalid cycle with model data.
    task automatic do_read(input string tag, input logic [7:0] a);
        logic [31:0] exp_d;
        exp_d = model_read(a);
        bus.sel  = 1'b1;
        bus.wr   = 1'b0;
        bus.addr = a;
        @(posedge clk); #1;
        bus.sel  = 1'b0;
        bus.addr = 8'($urandom);
        for (int k = 0; k <= RW; k++) begin
            check({tag, ".wait_ready"},  32'(bus.ready),  32'd0);
            check({tag, ".wait_rvalid"}, 32'(bus.rvalid), 32'd0);
            check({tag, ".wait_rdata"},  bus.rdata,       32'd0);
            if (k < RW) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        check({tag, ".rvalid"}, 32'(bus.rvalid), 32'd1);
        check({tag, ".rdata"},  bus.rdata,       exp_d);
        check({tag, ".err"},    32'(bus.err),    (int'(a) >= DEPTH) ? 32'd1 : 32'd0);
        check({tag, ".ready"},  32'(bus.ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ra;
        logic [31:0] rd;
        logic [3:0]  rs;

        model_reset();
        rst = 1'b1;
        bus.sel = 1'b0; bus.wr = 1'b0; bus.addr = 8'h00;
        bus.wdata = 32'h0; bus.wstrb = 4'h0;
        @(posedge clk); @(posedge clk); #1;
        check("reset.ready",  32'(bus.ready),  32'd1);
        check("reset.rvalid", 32'(bus.rvalid), 32'd0);
        check("reset.rdata",  bus.rdata,       32'd0);
        check("reset.err",    32'(bus.err),    32'd0);

        // Reset wins over a simultaneous write request.
        bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = 8'h40;
        bus.wdata = 32'h0000_0000; bus.wstrb = 4'hF;
        @(posedge clk); #1;
        check("rst_ovr.ready", 32'(bus.ready), 32'd1);
        check("rst_ovr.err",   32'(bus.err),   32'd0);
        bus.sel = 1'b0; bus.wr = 1'b0;
        rst = 1'b0;
        do_read("rst_ovr_rd", 8'h40);

        // Reset value readback.
        do_read("rd05", 8'h05);

        // Byte-strobed write.
        do_write("wr10", 8'h10, 32'hAABB_CCDD, 4'b0101);
        do_read("rd10", 8'h10);
        check("rd10.literal", mem_m[8'h10], 32'h12BB_56DD);

        // Back-to-back writes on consecutive edges.
        do_write("b2b1", 8'h01, 32'h0101_A5A5, 4'hF);
        do_write("b2b2", 8'h02, 32'h0202_5A5A, 4'hF);
        do_write("b2b3", 8'h03, 32'h0303_C3C3, 4'hF);
        do_read("b2b_rd1", 8'h01);
        do_read("b2b_rd2", 8'h02);
        do_read("b2b_rd3", 8'h03);

        // Zero strobe: no change, no error.
        do_write("wstrb0", 8'h01, 32'hFFFF_FFFF, 4'h0);
        do_read("wstrb0_rd", 8'h01);

        // Out-of-range write then read.
        do_write("oor_wr", 8'hF0, 32'hCAFE_F00D, 4'hF);
        @(posedge clk); #1;
        check("oor_wr.err_drop", 32'(bus.err), 32'd0);
        do_read("oor_rd", 8'hF0);
        do_read("top_in_range", 8'd199);
        do_read("first_oor", 8'd200);

        // sel held and addr changed during WAIT.
        do_write("w20", 8'h20, 32'h2020_2020, 4'hF);
        do_write("w21", 8'h21, 32'h2121_2121, 4'hF);
        bus.sel = 1'b1; bus.wr = 1'b0; bus.addr = 8'h20;
        @(posedge clk); #1;
        bus.addr = 8'h21;
        check("hold.ready0", 32'(bus.ready), 32'd0);
        for (int k = 1; k <= RW; k++) begin
            @(posedge clk); #1;
            check("hold.wait_rvalid", 32'(bus.rvalid), 32'd0);
            check("hold.wait_ready",  32'(bus.ready),  32'd0);
        end
        @(posedge clk); #1;
        check("hold.rvalid1", 32'(bus.rvalid), 32'd1);
        check("hold.rdata1",  bus.rdata,       32'h2020_2020);
        check("hold.ready1",  32'(bus.ready),  32'd1);
        @(posedge clk); #1;
        check("hold.second_ready",  32'(bus.ready),  32'd0);
        check("hold.second_rvalid", 32'(bus.rvalid), 32'd0);
        bus.sel = 1'b0;
        for (int k = 1; k <= RW; k++) begin
            @(posedge clk); #1;
            check("hold.wait2_rvalid", 32'(bus.rvalid), 32'd0);
        end
        @(posedge clk); #1;
        check("hold.rvalid2", 32'(bus.rvalid), 32'd1);
        check("hold.rdata2",  bus.rdata,       32'h2121_2121);

        // Reset during WAIT aborts the read and restores the bank.
        do_write("w30", 8'h30, 32'hDEAD_BEEF, 4'hF);
        bus.sel = 1'b1; bus.wr = 1'b0; bus.addr = 8'h30;
        @(posedge clk); #1;
        bus.sel = 1'b0;
        check("abort.ready0", 32'(bus.ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.ready",  32'(bus.ready),  32'd1);
        check("abort.rvalid", 32'(bus.rvalid), 32'd0);
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("abort.no_rvalid", 32'(bus.rvalid), 32'd0);
            check("abort.no_err",    32'(bus.err),    32'd0);
        end
        do_read("abort_rd30", 8'h30);

        // Randomized mix against the model.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) ra = 8'($urandom_range(200, 255));
            else                           ra = 8'($urandom_range(0, 15));
            rd = $urandom;
            rs = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) do_write("rnd_wr", ra, rd, rs);
            else                           do_read("rnd_rd", ra);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
